// File: rtl/fp_result_pack_fifo.sv
// rtl/fp_result_pack_fifo.sv - packs FP results (sign/exponent/significand/specials) into IEEE words and queues them
// FIFO of packed words plus {invalid, overflow, underflow} flags; packing happens at the push edge.
module fp_result_pack_fifo #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_s,
    input  logic [EXP_W+1:0]           in_e,
    input  logic [MAN_W:0]             in_m,
    input  logic                       in_nan,
    input  logic                       in_inf,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [EXP_W+MAN_W:0]       out_data,
    output logic [2:0]                 out_flags,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = 1 + EXP_W + MAN_W;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic signed [EXP_W+1:0] E_MAX = {2'b00, {EXP_W{1'b1}}};

    logic [DW+2:0]   mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [DW-1:0]   pack_data;
    logic [2:0]      pack_flags;
    logic            push, pop;

    // First match wins: NaN, infinity, zero/denormal significand, then exponent range.
    always_comb begin
        pack_data  = '0;
        pack_flags = 3'b000;
        if (in_nan) begin
            pack_data  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            pack_flags = 3'b100;
        end else if (in_inf) begin
            pack_data  = {in_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (!in_m[MAN_W]) begin
            pack_data  = {in_s, {(EXP_W+MAN_W){1'b0}}};
            pack_flags = {2'b00, |in_m[MAN_W-1:0]};
        end else if ($signed(in_e) >= E_MAX) begin
            pack_data  = {in_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            pack_flags = 3'b010;
        end else if (in_e[EXP_W+1] || (in_e == '0)) begin
            pack_data  = {in_s, {(EXP_W+MAN_W){1'b0}}};
            pack_flags = 3'b001;
        end else begin
            pack_data  = {in_s, in_e[EXP_W-1:0], in_m[MAN_W-1:0]};
        end
    end

    assign in_ready  = (count_q < FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem_q[rd_ptr_q][DW-1:0];
    assign out_flags = mem_q[rd_ptr_q][DW+2:DW];
    assign count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage is cleared on reset so the head reads as zero while empty after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= {pack_flags, pack_data};
            end
        end
    end

endmodule

// File: tb/tb_fp_result_pack_fifo.sv
// tb/tb_fp_result_pack_fifo.sv - self-checking bench for fp_result_pack_fifo against a queue-based reference model
module tb_fp_result_pack_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_s, in_nan, in_inf;
    logic [9:0]  in_e;
    logic [23:0] in_m;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_flags;
    logic [2:0]  count;

    int checks = 0;
    int failures = 0;
    logic [34:0] mq [$];

    always #5 clk = ~clk;

    fp_result_pack_fifo #(.EXP_W(8), .MAN_W(23), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_s(in_s), .in_e(in_e), .in_m(in_m), .in_nan(in_nan), .in_inf(in_inf),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_flags(out_flags), .count(count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [34:0] ref_pack(input logic s, input logic [9:0] e,
                                            input logic [23:0] m, input logic nan, input logic inf);
        int          ei;
        logic [31:0] d;
        logic [2:0]  f;
        ei = (e >= 10'd512) ? int'(e) - 1024 : int'(e);
        f  = 3'b000;
        if (nan) begin
            d = 32'h7FC00000;
            f = 3'b100;
        end else if (inf) begin
            d = {s, 31'h7F800000};
        end else if (m < 24'h800000) begin
            d = {s, 31'h0};
            f = (m != 0) ? 3'b001 : 3'b000;
        end else if (ei >= 255) begin
            d = {s, 31'h7F800000};
            f = 3'b010;
        end else if (ei <= 0) begin
            d = {s, 31'h0};
            f = 3'b001;
        end else begin
            d = {s, 8'(ei), m[22:0]};
        end
        return {f, d};
    endfunction

    // One clock: drive at negedge, compare against the model, then apply the edge to the model.
    task automatic cycle(input logic v, input logic s, input logic [9:0] e, input logic [23:0] m,
                         input logic nan, input logic inf, input logic ordy, output logic acc);
        logic [34:0] pk;
        @(negedge clk);
        in_valid = v; in_s = s; in_e = e; in_m = m; in_nan = nan; in_inf = inf; out_ready = ordy;
        #1;
        check("in_ready", in_ready, mq.size() < 4);
        check("out_valid", out_valid, mq.size() != 0);
        check("count", count, mq.size());
        if (mq.size() != 0) begin
            check("head_data", out_data, mq[0][31:0]);
            check("head_flags", out_flags, mq[0][34:32]);
        end
        acc = v && (mq.size() < 4);
        pk  = ref_pack(s, e, m, nan, inf);
        @(posedge clk);
        if (ordy && mq.size() != 0) void'(mq.pop_front());
        if (acc) mq.push_back(pk);
    endtask

    task automatic expect_head(input string tag, input logic [31:0] d, input logic [2:0] f);
        #2;
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_data"}, out_data, d);
        check({tag, "_flags"}, out_flags, f);
    endtask

    task automatic drain();
        logic a;
        int   n = 0;
        while (mq.size() != 0 && n < 20) begin
            cycle(1'b0, 1'b0, 10'd0, 24'd0, 1'b0, 1'b0, 1'b1, a);
            n++;
        end
        check("drain_bound", mq.size(), 0);
    endtask

    initial begin
        logic        a;
        logic        rs, rn, ri, rv, ro;
        logic [9:0]  re;
        logic [23:0] rm;
        int          n;

        rst_n = 1'b0; in_valid = 1'b0; in_s = 1'b0; in_e = '0; in_m = '0;
        in_nan = 1'b0; in_inf = 1'b0; out_ready = 1'b0;
        #3;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_count", count, 3'd0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_flags", out_flags, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        cycle(1'b1, 1'b0, 10'd127, 24'hC00000, 1'b0, 1'b0, 1'b1, a);
        check("first_push_acc", a, 1'b1);
        expect_head("normal", 32'h3FC00000, 3'b000);
        cycle(1'b1, 1'b1, 10'd255, 24'h800000, 1'b0, 1'b0, 1'b1, a);
        expect_head("overflow", 32'hFF800000, 3'b010);
        cycle(1'b1, 1'b0, 10'h3FB, 24'h800000, 1'b0, 1'b0, 1'b1, a);
        expect_head("underflow_e", 32'h00000000, 3'b001);
        cycle(1'b1, 1'b0, 10'd100, 24'h000001, 1'b0, 1'b0, 1'b1, a);
        expect_head("denormal", 32'h00000000, 3'b001);
        cycle(1'b1, 1'b0, 10'd100, 24'h000000, 1'b0, 1'b0, 1'b1, a);
        expect_head("zero", 32'h00000000, 3'b000);
        cycle(1'b1, 1'b1, 10'd3, 24'h812345, 1'b1, 1'b1, 1'b1, a);
        expect_head("nan", 32'h7FC00000, 3'b100);
        cycle(1'b1, 1'b0, 10'd3, 24'h812345, 1'b0, 1'b1, 1'b1, a);
        expect_head("inf", 32'h7F800000, 3'b000);
        cycle(1'b1, 1'b0, 10'd254, 24'hFFFFFF, 1'b0, 1'b0, 1'b1, a);
        expect_head("max_normal", 32'h7F7FFFFF, 3'b000);
        drain();

        // Fill to full with the consumer stalled, then release it while the 5th value is held.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 10'(100 + i), 24'h800000 | 24'(i), 1'b0, 1'b0, 1'b0, a);
            check("fill_acc", a, 1'b1);
        end
        #2;
        check("full_count", count, 3'd4);
        check("full_in_ready", in_ready, 1'b0);
        cycle(1'b1, 1'b0, 10'd104, 24'h800004, 1'b0, 1'b0, 1'b0, a);
        check("full_reject", a, 1'b0);
        n = 0;
        a = 1'b0;
        while (!a && n < 20) begin
            cycle(1'b1, 1'b0, 10'd104, 24'h800004, 1'b0, 1'b0, 1'b1, a);
            n++;
        end
        check("held_accept", a, 1'b1);
        check("held_wait_cycles", n, 2);
        drain();

        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 10'(50 + i), 24'hA00000, 1'b0, 1'b0, 1'b0, a);
        cycle(1'b1, 1'b0, 10'd60, 24'hB00000, 1'b0, 1'b0, 1'b1, a);
        #2;
        check("pushpop_count", count, 3'd2);
        drain();

        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 10'(20 + i), 24'h900000, 1'b0, 1'b0, 1'b0, a);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_count", count, 3'd0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_out_data", out_data, 32'h0);
        check("midrst_out_flags", out_flags, 3'b000);
        mq.delete();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 10'd130, 24'hC80000, 1'b0, 1'b0, 1'b0, a);
        #2;
        check("post_rst_count", count, 3'd1);

        for (int k = 0; k < 300; k++) begin
            rv = ($urandom_range(0, 3) != 0);
            ro = ($urandom_range(0, 2) != 0);
            rs = 1'($urandom);
            rn = ($urandom_range(0, 9) == 0);
            ri = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 5))
                0: re = 10'($urandom);
                1: re = 10'($urandom_range(0, 2) == 0 ? 0 : ($urandom_range(0, 1) ? 255 : 254));
                default: re = 10'($urandom_range(1, 254));
            endcase
            rm = ($urandom_range(0, 7) == 0) ? 24'($urandom_range(0, 3)) : (24'h800000 | 24'($urandom));
            cycle(rv, rs, re, rm, rn, ri, ro, a);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_result_pack_fifo.md
FP_RESULT_PACK_FIFO -- requirements
Module: fp_result_pack_fifo

Interface
REQ-001 Parameter EXP_W, default 8: packed exponent width.
REQ-002 Parameter MAN_W, default 23: packed fraction width, hidden bit excluded.
REQ-003 Parameter DEPTH, default 4: FIFO entries; power of two, minimum 2.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  producer has a result this cycle.
REQ-007 in_ready  out  1  block can accept a result this cycle.
REQ-008 in_s  in  1  result sign.
REQ-009 in_e  in  EXP_W+2  biased exponent, two's complement; may be out of range.
REQ-010 in_m  in  MAN_W+1  significand; MSB is the hidden bit.
REQ-011 in_nan  in  1  result is NaN.
REQ-012 in_inf  in  1  result is infinity.
REQ-013 out_valid  out  1  head entry is valid.
REQ-014 out_ready  in  1  consumer takes the head entry this cycle.
REQ-015 out_data  out  1+EXP_W+MAN_W  packed word {sign, exponent, fraction}.
REQ-016 out_flags  out  3  {invalid, overflow, underflow} for the head entry.
REQ-017 count  out  clog2(DEPTH)+1  number of occupied entries.

Function
REQ-018 Push occurs when in_valid and in_ready are both 1 at a rising edge.
REQ-019 Pop occurs when out_valid and out_ready are both 1 at a rising edge.
REQ-020 in_ready is 1 exactly when count < DEPTH; no pass-through when full, even if a pop happens in the same cycle.
REQ-021 out_valid is 1 exactly when count != 0; out_data and out_flags show the head entry.
REQ-022 Simultaneous push and pop: count stays unchanged, and both pointers advance.
REQ-023 Read and write pointers wrap modulo DEPTH; entries leave in push order.
REQ-024 Latency: an entry pushed into an empty FIFO appears on out_valid/out_data in the cycle after the accepting edge.
REQ-025 Pack priority at push, first match wins: NaN > inf > zero/denormal > overflow > underflow > normal.
REQ-026 in_nan=1: data = {0, all ones, 1, zeros}, the canonical quiet NaN; flags = 100. Sign and in_inf are ignored.
REQ-027 in_inf=1: data = {in_s, all ones, zeros}; flags = 000.
REQ-028 in_m MSB=0: data = {in_s, zeros}; underflow flag = 1 if in_m != 0, otherwise flags = 000.
REQ-029 signed in_e >= 2^EXP_W-1: data = {in_s, all ones, zeros}; flags = 010.
REQ-030 signed in_e <= 0: data = {in_s, zeros}; flags = 001.
REQ-031 Otherwise: data = {in_s, in_e[EXP_W-1:0], in_m[MAN_W-1:0]}; flags = 000.
REQ-032 Packing is computed from the inputs at the push edge and stored; later input changes do not affect stored entries.
REQ-033 Inputs other than in_valid are don't-care when no push occurs.

Reset
REQ-034 When rst_n is low, the following are forced immediately, independent of clk: pointers and count = 0, out_valid = 0, in_ready = 1.
REQ-035 Reset also clears all storage, so out_data = 0 and out_flags = 000 during and after reset.
REQ-036 Reset mid-operation discards all entries; no partial pop or push completes on the edge where rst_n is low.
REQ-037 The first push is accepted on the first rising edge with rst_n high.

Verification (EXP_W=8, MAN_W=23, DEPTH=4)
REQ-038 Normal value: push s=0, e=127, m=24'hC00000, with out_ready=1 -> next cycle out_valid=1, out_data=32'h3FC00000, out_flags=000.
REQ-039 Overflow and underflow:
- push s=1, e=255, m=24'h800000 -> 32'hFF800000, flags 010.
- push s=0, e=-5, m=24'h800000 -> 32'h00000000, flags 001.
- push m=24'h000001 -> 32'h00000000, flags 001.
REQ-040 Specials: push in_nan=1 and in_inf=1 with s=1 -> 32'h7FC00000, flags 100; push in_inf=1 only, s=0 -> 32'h7F800000, flags 000.
REQ-041 Full and wrap:
- out_ready=0; push 5 distinct values -> in_ready=0 after the 4th push, count=4, 5th value held by the producer.
- then out_ready=1 with in_valid held -> one pop per cycle, 5th value accepted once count<4, all 5 values output in push order across the pointer wrap.
REQ-042 Simultaneous push/pop at count=2 -> count remains 2, and order is preserved.
REQ-043 Reset mid-operation: count=3, drop rst_n between clock edges -> out_valid=0, count=0, in_ready=1, out_data=0 before the next edge.
